fi_inject_ctrl: RTL

- Synthesizable in-design fault-injection controller, instantiated inside nvdla_top beside the logic under test.
- Owns the free-running core-clock cycle counter that the injection testbench samples (top.nvdla_top.counter).
- Accepts an armed injection request and, at the target cycle, applies a bit mask to a monitored datapath word for a programmed number of cycles. Supported corruptions: flip, stuck-at-0, stuck-at-1.
- It is the responder side of the testbench's force/display loop. Injections become cycle-exact and reproducible instead of being forced from the bench.

---
 rtl/fi_pkg.sv | 35 +++
 rtl/fi_mask_apply.sv | 26 ++
 rtl/fi_inject_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fi_pkg.sv
// Shared types and constants for the fault-injection controller.
// Holds the corruption-mode and FSM state enums plus the LFSR tap table.
package fi_pkg;

  typedef enum logic [1:0] {
    FI_FLIP   = 2'd0,
    FI_STUCK0 = 2'd1,
    FI_STUCK1 = 2'd2,
    FI_RSVD   = 2'd3
  } fi_mode_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StActive = 2'd2,
    StDone   = 2'd3
  } fi_state_e;

  // Right-shifting Galois feedback masks for maximal-length sequences.
  localparam logic [7:0]  FiTaps8  = 8'hB8;
  localparam logic [15:0] FiTaps16 = 16'hB400;
  localparam logic [31:0] FiTaps32 = 32'h8020_0003;

  // Widths outside the table fall back to a single MSB tap: still never
  // reaches zero from a nonzero seed, though the period is short.
  function automatic logic [63:0] fi_lfsr_taps(int unsigned width);
    case (width)
      8:       return {56'd0, FiTaps8};
      16:      return {48'd0, FiTaps16};
      32:      return {32'd0, FiTaps32};
      default: return 64'd1 << (width - 1);
    endcase
  endfunction

endpackage

// File: rtl/fi_mask_apply.sv
// Combinational corruption stage: applies mask to a datapath word by mode.
// Shareable between several injection controllers.
module fi_mask_apply
  import fi_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] mask,
  input  fi_mode_e          mode,
  input  logic              enable,
  output logic [DATA_W-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    if (enable) begin
      unique case (mode)
        FI_STUCK0:        data_out = data_in & ~mask;
        FI_STUCK1:        data_out = data_in | mask;
        FI_FLIP, FI_RSVD: data_out = data_in ^ mask;
      endcase
    end
  end

endmodule

// File: rtl/fi_inject_ctrl.sv
// Cycle-exact fault-injection controller with free-running core cycle counter.
// Define FI_LFSR_MASK_EN to replace the constant mask by a per-cycle LFSR mask.
module fi_inject_ctrl
  import fi_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned DUR_W  = 8
) (
  input  logic              dla_core_clk,
  input  logic              dla_core_rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_target,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic [1:0]        cfg_mode,
  input  logic [DUR_W-1:0]  cfg_dur,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  counter,
  output logic              fi_active,
  output logic              fi_done,
  output logic              fi_miss
);

  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
  localparam logic [DUR_W-1:0]  DurOne  = DUR_W'(1);
  localparam logic [DATA_W-1:0] MaskOne = DATA_W'(1);

  fi_state_e          state_q;
  fi_mode_e           mode_q;
  logic [CNT_W-1:0]   counter_q;
  logic [CNT_W-1:0]   target_q;
  logic [DATA_W-1:0]  mask_q;
  logic [DUR_W-1:0]   dur_q;
  logic [DUR_W-1:0]   remain_q;
  logic               fi_active_q;
  logic               fi_done_q;
  logic               fi_miss_q;
  logic               handshake;
  logic [DATA_W-1:0]  mask_seed;
  logic [DATA_W-1:0]  mask_active_next;

`ifdef FI_LFSR_MASK_EN
  localparam logic [63:0]       TapsAll = fi_lfsr_taps(DATA_W);
  localparam logic [DATA_W-1:0] Taps    = TapsAll[DATA_W-1:0];

  function automatic logic [DATA_W-1:0] lfsr_step(logic [DATA_W-1:0] s);
    return s[0] ? ((s >> 1) ^ Taps) : (s >> 1);
  endfunction

  // An all-zero seed would lock the LFSR at zero.
  assign mask_seed        = (cfg_mask == '0) ? MaskOne : cfg_mask;
  assign mask_active_next = lfsr_step(mask_q);
`else
  assign mask_seed        = cfg_mask;
  assign mask_active_next = mask_q;
`endif

  assign cfg_ready = (state_q == StIdle) || (state_q == StDone);
  // Abort has priority over a simultaneous configuration request.
  assign handshake = cfg_valid && cfg_ready && !abort;

  always_ff @(posedge dla_core_clk) begin
    if (dla_core_rst) begin
      state_q     <= StIdle;
      mode_q      <= FI_FLIP;
      counter_q   <= '0;
      target_q    <= '0;
      mask_q      <= '0;
      dur_q       <= '0;
      remain_q    <= '0;
      fi_active_q <= 1'b0;
      fi_done_q   <= 1'b0;
      fi_miss_q   <= 1'b0;
    end else begin
      counter_q <= counter_q + CntOne;
      unique case (state_q)
        StIdle, StDone: begin
          if (handshake) begin
            target_q  <= cfg_target;
            mask_q    <= mask_seed;
            mode_q    <= fi_mode_e'(cfg_mode);
            dur_q     <= cfg_dur;
            fi_done_q <= 1'b0;
            if (cfg_target > counter_q) begin
              state_q   <= StArmed;
              fi_miss_q <= 1'b0;
            end else begin
              state_q   <= StDone;
              fi_miss_q <= 1'b1;
            end
          end
        end
        StArmed: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (counter_q == target_q) begin
            state_q     <= StActive;
            fi_active_q <= 1'b1;
            remain_q    <= (dur_q == '0) ? DurOne : dur_q;
          end
        end
        StActive: begin
          if (abort) begin
            state_q     <= StIdle;
            fi_active_q <= 1'b0;
          end else begin
            mask_q <= mask_active_next;
            if (remain_q == DurOne) begin
              state_q     <= StDone;
              fi_active_q <= 1'b0;
              fi_done_q   <= 1'b1;
            end else begin
              remain_q <= remain_q - DurOne;
            end
          end
        end
      endcase
    end
  end

  fi_mask_apply #(
    .DATA_W (DATA_W)
  ) u_mask_apply (
    .data_in  (data_in),
    .mask     (mask_q),
    .mode     (mode_q),
    .enable   (fi_active_q),
    .data_out (data_out)
  );

  assign counter   = counter_q;
  assign fi_active = fi_active_q;
  assign fi_done   = fi_done_q;
  assign fi_miss   = fi_miss_q;

endmodule
